// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampling, 3-sample majority vote, optional parity,
// 1/2 stop bits) feeding a first-word-fall-through FIFO with sticky error flags.
module uart_rx_fifo #(
    parameter int OS_DIV     = 9,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     rx,
    input  logic                     rd_en,
    output logic [DATA_BITS-1:0]     rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    output logic                     frame_err,
    output logic                     parity_err,
    input  logic                     clr_err
);
    localparam int TW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2, S_WAIT_HIGH
    } state_t;

    state_t                 state, state_nxt;
    logic                   rx_m, rx_s;
    logic [TW-1:0]          tick_cnt;
    logic                   tick, mid, last;
    logic [3:0]             sub, sub_nxt;
    logic [BW-1:0]          bit_cnt, bit_nxt;
    logic                   par_bad, par_bad_nxt;
    logic                   samp7, samp8, maj;
    logic [DATA_BITS-1:0]   shreg;
    logic                   shift_en, push, ferr_set, perr_set;
    logic [DATA_BITS-1:0]   mem [DEPTH];
    logic [AW-1:0]          wp, rp;
    logic                   do_pop, push_ok, drop;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign tick = (tick_cnt == TW'(OS_DIV - 1));
    assign mid  = tick && (sub == 4'd9);
    assign last = tick && (sub == 4'd15);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Majority of the samples taken at sub 7, 8 and the live sample at sub 9
    assign maj = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);

    always_ff @(posedge clk) begin
        if (tick && sub == 4'd7) samp7 <= rx_s;
        if (tick && sub == 4'd8) samp8 <= rx_s;
        if (shift_en)            shreg <= {maj, shreg[DATA_BITS-1:1]};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= S_IDLE;
            sub     <= '0;
            bit_cnt <= '0;
            par_bad <= 1'b0;
        end else begin
            state   <= state_nxt;
            sub     <= sub_nxt;
            bit_cnt <= bit_nxt;
            par_bad <= par_bad_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sub_nxt     = sub;
        bit_nxt     = bit_cnt;
        par_bad_nxt = par_bad;
        shift_en    = 1'b0;
        push        = 1'b0;
        ferr_set    = 1'b0;
        perr_set    = 1'b0;
        if (tick) sub_nxt = sub + 1'b1;
        case (state)
            S_IDLE: begin
                sub_nxt     = '0;
                bit_nxt     = '0;
                par_bad_nxt = 1'b0;
                if (tick && !rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (mid && maj)  state_nxt = S_IDLE;
                else if (last)   state_nxt = S_DATA;
            end
            S_DATA: begin
                shift_en = mid;
                if (last) begin
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        bit_nxt = '0;
                        if (PARITY_EN != 0) state_nxt = S_PARITY;
                        else                state_nxt = S_STOP;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (mid)  par_bad_nxt = (maj != (^shreg ^ 1'(PARITY_ODD)));
                if (last) state_nxt = S_STOP;
            end
            S_STOP, S_STOP2: begin
                // The last stop bit ends the frame mid-bit so the next start edge is not missed
                if (mid) begin
                    if (!maj) begin
                        ferr_set  = 1'b1;
                        state_nxt = S_WAIT_HIGH;
                    end else if (state == S_STOP2 || STOP_BITS != 2) begin
                        perr_set  = par_bad;
                        push      = !par_bad;
                        state_nxt = S_IDLE;
                    end
                end else if (last) begin
                    state_nxt = S_STOP2;
                end
            end
            S_WAIT_HIGH: begin
                sub_nxt = '0;
                if (rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign do_pop  = rd_en && !empty;
    assign push_ok = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign rd_data = empty ? '0 : mem[rp];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= shreg;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            if (push_ok && !do_pop)      level <= level + 1'b1;
            else if (!push_ok && do_pop) level <= level - 1'b1;
        end
    end

    // A flag being set in the same cycle as clr_err stays set
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (drop)          overrun <= 1'b1;
            else if (clr_err)  overrun <= 1'b0;
            if (ferr_set)      frame_err <= 1'b1;
            else if (clr_err)  frame_err <= 1'b0;
            if (perr_set)      parity_err <= 1'b1;
            else if (clr_err)  parity_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: default 8N1 instance plus an even-parity instance.
module tb_uart_rx_fifo;
    localparam int BIT   = 144;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rx = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, overrun, frame_err, parity_err;
    logic [3:0] level;

    logic       rx_p = 1'b1, rd_en_p = 1'b0;
    logic [7:0] rd_data_p;
    logic       empty_p, full_p, overrun_p, frame_err_p, parity_err_p;
    logic [3:0] level_p;

    uart_rx_fifo dut (
        .clk(clk), .nrst(nrst), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .level(level), .overrun(overrun),
        .frame_err(frame_err), .parity_err(parity_err), .clr_err(clr_err)
    );

    uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .nrst(nrst), .rx(rx_p), .rd_en(rd_en_p), .rd_data(rd_data_p),
        .empty(empty_p), .full(full_p), .level(level_p), .overrun(overrun_p),
        .frame_err(frame_err_p), .parity_err(parity_err_p), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0, exp_ferr = 1'b0, exp_perr = 1'b0;
    bit         reader_on = 1'b0, force_rd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Pops whenever the DUT presents an entry and reading is enabled
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            rd_en = 1'b0;
            if (nrst && !empty && (reader_on || force_rd)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry: actual %0h required none", rd_data);
                end else begin
                    chk("pop_data", rd_data, exp_q.pop_front());
                end
                rd_en = 1'b1;
            end else if (force_rd) begin
                rd_en = 1'b1;
            end
        end
    endtask

    task automatic set_line(input bit sel, input logic b);
        if (sel) rx_p = b;
        else     rx   = b;
    endtask

    task automatic send_bit(input bit sel, input logic b);
        set_line(sel, b);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop_v,
                              input bit par_en, input logic par_v, input int glitch_bit);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                set_line(sel, d[i]);
                repeat (72) @(negedge clk);
                set_line(sel, ~d[i]);
                repeat (9) @(negedge clk);
                set_line(sel, d[i]);
                repeat (63) @(negedge clk);
            end else begin
                send_bit(sel, d[i]);
            end
        end
        if (par_en) send_bit(sel, par_v);
        send_bit(sel, stop_v);
        set_line(sel, 1'b1);
    endtask

    // Reference model: a good frame lands in the FIFO unless it is already full
    task automatic send_byte(input logic [7:0] d, input bit stop_ok, input int glitch_bit);
        if (reader_on || force_rd) repeat (2*DEPTH + 4) @(negedge clk);
        if (!stop_ok)                exp_ferr = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else                         exp_ovr = 1'b1;
        send_frame(1'b0, d, stop_ok, 1'b0, 1'b0, glitch_bit);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       pv;
        bit         good, bad;
        int         g, mode;

        fork
            monitor_loop();
        join_none

        repeat (5) @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_flags", {overrun, frame_err, parity_err}, 0);
        chk("rst_p_state", {empty_p, full_p, overrun_p, frame_err_p, parity_err_p}, 5'b10000);
        nrst = 1'b1;
        repeat (20) @(negedge clk);

        // Even parity: 0x07 has three ones so the parity bit must be 1
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, -1);
        chk("par_good_level", level_p, 1);
        chk("par_good_data", rd_data_p, 8'h07);
        chk("par_good_flag", parity_err_p, 0);
        rd_en_p = 1'b1;
        @(negedge clk);
        rd_en_p = 1'b0;
        chk("par_pop_empty", empty_p, 1);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b0, -1);
        chk("par_bad_flag", parity_err_p, 1);
        chk("par_bad_level", level_p, 0);
        pulse_clr();
        chk("par_clr", parity_err_p, 0);
        for (int n = 0; n < 5; n++) begin
            d    = 8'($urandom);
            good = 1'($urandom_range(0, 1));
            pv   = good ? (^d) : ~(^d);
            if (!good) exp_perr = 1'b1;
            send_frame(1'b1, d, 1'b1, 1'b1, pv, -1);
            chk("par_rand_level", level_p, good ? 1 : 0);
            if (good) begin
                chk("par_rand_data", rd_data_p, d);
                rd_en_p = 1'b1;
                @(negedge clk);
                rd_en_p = 1'b0;
            end
        end
        chk("par_rand_sticky", parity_err_p, exp_perr);
        pulse_clr();

        // Single 8N1 byte, entry appears only after the stop bit decision
        exp_q.push_back(8'hA5);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0, d[0] ^ d[0] ^ exp_q[0][i]);
        chk("t1_empty_before_stop", empty, 1);
        send_bit(1'b0, 1'b1);
        chk("t1_level", level, 1);
        chk("t1_empty", empty, 0);
        chk("t1_data", rd_data, exp_q[0]);
        reader_on = 1'b1;
        repeat (4) @(negedge clk);
        reader_on = 1'b0;
        chk("t1_drained", exp_q.size(), 0);
        chk("t1_empty_after_pop", empty, 1);

        // Nine back-to-back bytes with no reads: the ninth overruns
        for (int k = 1; k <= 9; k++) send_byte(8'(k), 1'b1, -1);
        repeat (20) @(negedge clk);
        chk("t2_level", level, exp_q.size());
        chk("t2_full", full, 1);
        chk("t2_overrun", overrun, exp_ovr);
        reader_on = 1'b1;
        repeat (40) @(negedge clk);
        chk("t2_drained", exp_q.size(), 0);
        chk("t2_empty", empty, 1);
        chk("t2_overrun_sticky", overrun, 1);
        pulse_clr();
        chk("t2_overrun_clr", overrun, 0);

        // Stop bit low, then a long break, then a clean byte
        send_byte(8'h3C, 1'b0, -1);
        rx = 1'b0;
        repeat (2000) @(negedge clk);
        rx = 1'b1;
        repeat (2*BIT) @(negedge clk);
        chk("t3_frame_err", frame_err, exp_ferr);
        chk("t3_level", level, 0);
        send_byte(8'h55, 1'b1, -1);
        repeat (BIT) @(negedge clk);
        chk("t3_next_drained", exp_q.size(), 0);
        pulse_clr();
        chk("t3_clr", frame_err, 0);

        // Short start glitch is rejected; one-tick glitch mid-bit is outvoted
        rx = 1'b0;
        repeat (27) @(negedge clk);
        rx = 1'b1;
        repeat (3*BIT) @(negedge clk);
        chk("t5_no_entry", level, 0);
        chk("t5_no_flags", {overrun, frame_err, parity_err}, 0);
        send_byte(8'hFF, 1'b1, 4);
        repeat (BIT) @(negedge clk);
        chk("t5_glitch_drained", exp_q.size(), 0);

        // Randomised frames, read modes and occasional bad stop bits
        for (int n = 0; n < 12; n++) begin
            mode      = $urandom_range(0, 2);
            reader_on = (mode == 0);
            force_rd  = (mode == 1);
            d   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            g   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            send_byte(d, !bad, g);
            if (bad) repeat (3*BIT) @(negedge clk);
            else     repeat ($urandom_range(0, 200)) @(negedge clk);
            if (mode == 2) chk("rand_level", level, exp_q.size());
        end
        force_rd  = 1'b0;
        reader_on = 1'b1;
        repeat (3*BIT) @(negedge clk);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_level_end", level, 0);
        chk("rand_overrun", overrun, exp_ovr);
        chk("rand_frame_err", frame_err, exp_ferr);
        pulse_clr();

        // Reset in the middle of a frame with three entries queued
        reader_on = 1'b0;
        send_byte(8'h3C, 1'b0, -1);
        repeat (2*BIT) @(negedge clk);
        for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1, -1);
        repeat (BIT) @(negedge clk);
        chk("t6_level_before", level, 3);
        chk("t6_ferr_before", frame_err, 1);
        d = 8'($urandom);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, d[i]);
        rx = d[4];
        repeat (BIT/2) @(negedge clk);
        nrst = 1'b0;
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_state", {empty, full}, 2'b10);
        chk("t6_rst_rd_data", rd_data, 0);
        chk("t6_rst_flags", {overrun, frame_err, parity_err}, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (2*BIT) @(negedge clk);
        chk("t6_quiet_after_rst", level, 0);
        reader_on = 1'b1;
        send_byte(8'h81, 1'b1, -1);
        repeat (BIT) @(negedge clk);
        chk("t6_next_drained", exp_q.size(), 0);
        chk("t6_flags_end", {overrun, frame_err}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
